// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared types and constants for the ex_div divider
package ex_div_pkg;

    localparam int DATA_W   = 32;
    localparam int RESULT_W = 64;
    localparam int CNT_W    = 6;

    // Count value on the edge that performs the final (32nd) quotient bit
    localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

    // alu_op codes that select this unit in EX
    localparam logic [5:0] ALU_OP_DIV  = 6'h1A;
    localparam logic [5:0] ALU_OP_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        ST_FREE        = 2'd0,
        ST_DIV_BY_ZERO = 2'd1,
        ST_ON          = 2'd2,
        ST_END         = 2'd3
    } div_state_e;

    // Two's complement negate when en is set
    function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
        return en ? (~v + 32'd1) : v;
    endfunction

    // Magnitude of a possibly-signed operand
    function automatic logic [DATA_W-1:0] abs_if(input logic is_signed, input logic [DATA_W-1:0] v);
        return neg_if(is_signed && v[DATA_W-1], v);
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - EX-stage handshake bundle for ex_div (div_zero_o with DIV_ZERO_FLAG_EN)
interface ex_div_if;
    import ex_div_pkg::*;

    logic                start_i;
    logic                signed_i;
    logic                annul_i;
    logic [DATA_W-1:0]   dividend_i;
    logic [DATA_W-1:0]   divisor_i;
    logic [RESULT_W-1:0] result_o;
    logic                ready_o;
    logic                stall_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                div_zero_o;
`endif

    modport master (
        output start_i, signed_i, annul_i, dividend_i, divisor_i,
        input  result_o, ready_o, stall_o
`ifdef DIV_ZERO_FLAG_EN
        , input div_zero_o
`endif
    );

    modport slave (
        input  start_i, signed_i, annul_i, dividend_i, divisor_i,
        output result_o, ready_o, stall_o
`ifdef DIV_ZERO_FLAG_EN
        , output div_zero_o
`endif
    );

endinterface

// File: rtl/ex_div_div_step.sv
// rtl/ex_div_div_step.sv - one restoring shift-subtract step of the divider
module div_step
    import ex_div_pkg::*;
(
    input  logic [DATA_W:0]   part_rem_i,
    input  logic              dividend_bit_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W:0]   next_rem_o,
    output logic              q_bit_o
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        shifted    = {part_rem_i, dividend_bit_i};
        trial      = shifted - {2'b00, divisor_i};
        q_bit_o    = ~trial[DATA_W+1];
        next_rem_o = q_bit_o ? trial[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative 32-bit DIV/DIVU unit (optional div_zero_o via DIV_ZERO_FLAG_EN)
module ex_div
    import ex_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ex_div_if.slave  bus
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [RESULT_W-1:0] result_q, result_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                dz_q, dz_d;
`endif

    logic [DATA_W:0]     step_rem;
    logic                step_bit;
    logic [DATA_W-1:0]   fin_quo;
    logic [DATA_W-1:0]   fin_rem;
    logic                take_start;

    // Quotient bits leave quo_q's MSB as dividend bits and re-enter at its LSB
    div_step u_div_step (
        .part_rem_i     (rem_q),
        .dividend_bit_i (quo_q[DATA_W-1]),
        .divisor_i      (dvs_q),
        .next_rem_o     (step_rem),
        .q_bit_o        (step_bit)
    );

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q      <= dz_d;
`endif
        end
    end

    // Next state, operand capture, iteration and sign correction
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d       = dz_q;
`endif
        take_start = bus.start_i && !bus.annul_i;
        fin_quo    = neg_if(neg_quo_q, {quo_q[DATA_W-2:0], step_bit});
        fin_rem    = neg_if(neg_rem_q, step_rem[DATA_W-1:0]);

        unique case (state_q)
            ST_FREE: begin
                if (take_start) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = abs_if(bus.signed_i, bus.dividend_i);
                    dvs_d     = abs_if(bus.signed_i, bus.divisor_i);
                    neg_quo_d = bus.signed_i && (bus.dividend_i[DATA_W-1] ^ bus.divisor_i[DATA_W-1]);
                    neg_rem_d = bus.signed_i && bus.dividend_i[DATA_W-1];
                    if (bus.divisor_i == '0) begin
                        // Zero divisor: result is fixed now, from the raw dividend
                        result_d = {bus.dividend_i, 32'hFFFF_FFFF};
                        state_d  = ST_DIV_BY_ZERO;
`ifdef DIV_ZERO_FLAG_EN
                        dz_d     = 1'b1;
`endif
                    end else begin
                        state_d  = ST_ON;
`ifdef DIV_ZERO_FLAG_EN
                        dz_d     = 1'b0;
`endif
                    end
                end
            end
            ST_DIV_BY_ZERO: begin
                state_d = ST_END;
            end
            ST_ON: begin
                rem_d = step_rem;
                quo_d = {quo_q[DATA_W-2:0], step_bit};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    result_d = {fin_rem, fin_quo};
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                if (!bus.start_i) begin
                    state_d = ST_FREE;
                end
            end
            default: begin
                state_d = ST_FREE;
            end
        endcase

        // A flush wins over everything and never yields a result
        if (bus.annul_i) begin
            state_d = ST_FREE;
        end
    end

    // Outputs: result gated by ready, stall while work is pending
    always_comb begin
        bus.ready_o  = (state_q == ST_END);
        bus.result_o = (state_q == ST_END) ? result_q : '0;
        bus.stall_o  = (state_q == ST_DIV_BY_ZERO) || (state_q == ST_ON) ||
                       ((state_q == ST_FREE) && bus.start_i && !bus.annul_i && rst_n);
`ifdef DIV_ZERO_FLAG_EN
        bus.div_zero_o = (state_q == ST_END) && dz_q;
`endif
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - randomized self-checking bench for ex_div
module tb_ex_div;
    import ex_div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   stall_gap;

    ex_div_if bus();

    ex_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] qv;
        logic [63:0] rv;
        longint sa;
        longint sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qv = sa / sb;
            rv = sa % sb;
        end else begin
            qv = {32'd0, a / b};
            rv = {32'd0, a % b};
        end
        return {rv[31:0], qv[31:0]};
    endfunction

    // Transaction-level model: edges remaining, done flag, expected result
    int          m_left;
    bit          m_done;
    logic [63:0] m_res;
    bit          m_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_res = '0; m_dz = 0;
        end else if (bus.annul_i) begin
            m_left = 0; m_done = 0;
        end else if (m_done) begin
            if (!bus.start_i) m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (bus.start_i) begin
            m_res  = ref_div(bus.signed_i, bus.dividend_i, bus.divisor_i);
            m_dz   = (bus.divisor_i == 32'd0);
            m_left = m_dz ? 1 : 32;
        end
    end

    // Every-cycle compare of DUT outputs against the model
    always @(negedge clk) begin : cmp
        logic [65:0] exp_v;
        logic [65:0] act_v;
        logic        exp_stall;
        exp_stall = rst_n && !m_done && ((m_left > 0) || (bus.start_i && !bus.annul_i));
        exp_v = {m_done, exp_stall, (m_done ? m_res : 64'd0)};
        act_v = {bus.ready_o, bus.stall_o, bus.result_o};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t: {ready,stall,result} got %h expected %h", $time, act_v, exp_v);
        end
`ifdef DIV_ZERO_FLAG_EN
        vectors++;
        if (bus.div_zero_o !== (m_done && m_dz)) begin
            miscompares++;
            $display("FAIL cycle_div_zero t=%0t: got %b expected %b", $time, bus.div_zero_o, m_done && m_dz);
        end
`endif
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue a divide and wait for ready; operands are scrambled after capture
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int n);
        bus.signed_i = sgn; bus.dividend_i = a; bus.divisor_i = b; bus.start_i = 1'b1;
        n = 0; res = '0; stall_gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++; #1;
            if (n == 1) begin
                bus.dividend_i = $urandom; bus.divisor_i = $urandom; bus.signed_i = 1'($urandom);
            end
            if (bus.ready_o) begin
                res = bus.result_o;
                break;
            end
            if (!bus.stall_o) stall_gap = 1;
        end
        if (!bus.ready_o) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: ready_o got 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic drop_start();
        bus.start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [63:0] res;
    logic [63:0] exp_r;
    int          n;

    initial begin
        bus.start_i = 0; bus.signed_i = 0; bus.annul_i = 0;
        bus.dividend_i = 0; bus.divisor_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_stall", 64'(bus.stall_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        rst_n = 1'b1;

        // 100/7 unsigned, latency, stall, END hold and release
        do_div(1'b0, 32'd100, 32'd7, res, n);
        chk("u100_7", res, {32'd2, 32'd14});
        chk("u100_7_latency", 64'(n), 64'd33);
        chk("u100_7_stall", 64'(stall_gap), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 64'(bus.ready_o), 64'd1);
            chk("hold_result", bus.result_o, {32'd2, 32'd14});
        end
        drop_start();
        chk("drop_ready", 64'(bus.ready_o), 64'd0);
        chk("drop_result", bus.result_o, 64'd0);

        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, n);
        chk("s_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        drop_start();
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, res, n);
        chk("u_fff9_2", res, {32'd1, 32'h7FFF_FFFC});
        drop_start();
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, n);
        chk("s_min_m1", res, {32'd0, 32'h8000_0000});
        drop_start();

        // Divide by zero
        do_div(1'b1, 32'h1234, 32'd0, res, n);
        chk("dbz_result", res, {32'h1234, 32'hFFFF_FFFF});
        chk("dbz_latency", 64'(n), 64'd2);
`ifdef DIV_ZERO_FLAG_EN
        chk("dbz_flag", 64'(bus.div_zero_o), 64'd1);
`endif
        drop_start();

        // start and annul together in FREE stays idle
        bus.start_i = 1; bus.annul_i = 1; bus.dividend_i = 32'd77; bus.divisor_i = 32'd5;
        @(posedge clk); #1;
        chk("start_annul_stall", 64'(bus.stall_o), 64'd0);
        @(posedge clk); #1;
        chk("start_annul_ready", 64'(bus.ready_o), 64'd0);
        bus.annul_i = 0;
        do_div(1'b1, 32'hFFFF_FFEC, 32'd3, res, n);
        chk("s_m20_3", res, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
        chk("s_m20_3_latency", 64'(n), 64'd33);
        drop_start();

        // Annul at iteration 10
        bus.signed_i = 0; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3; bus.start_i = 1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1; bus.annul_i = 1; bus.start_i = 0;
        @(posedge clk); #1;
        bus.annul_i = 0;
        chk("annul_ready", 64'(bus.ready_o), 64'd0);
        chk("annul_stall", 64'(bus.stall_o), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("annul_idle_ready", 64'(bus.ready_o), 64'd0);
        end
        do_div(1'b0, 32'd9, 32'd3, res, n);
        chk("u9_3", res, {32'd0, 32'd3});
        chk("u9_3_latency", 64'(n), 64'd33);
        drop_start();

        // Reset at iteration 20 with start held across release
        bus.signed_i = 0; bus.dividend_i = 32'd12345; bus.divisor_i = 32'd17; bus.start_i = 1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1; rst_n = 0;
        #1;
        chk("midreset_ready", 64'(bus.ready_o), 64'd0);
        chk("midreset_stall", 64'(bus.stall_o), 64'd0);
        chk("midreset_result", bus.result_o, 64'd0);
        bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++; #1;
            if (bus.ready_o) break;
        end
        chk("post_reset_result", bus.result_o, {32'd0, 32'd10});
        chk("post_reset_latency", 64'(n), 64'd33);
        drop_start();

        // Randomized divides, some flushed mid-flight
        for (int k = 0; k < 150; k++) begin
            logic        sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                bus.signed_i = sgn; bus.dividend_i = a; bus.divisor_i = b; bus.start_i = 1;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1; bus.annul_i = 1; bus.start_i = 0;
                @(posedge clk); #1;
                bus.annul_i = 0;
                chk("rand_annul_ready", 64'(bus.ready_o), 64'd0);
            end else begin
                exp_r = ref_div(sgn, a, b);
                do_div(sgn, a, b, res, n);
                chk("rand_result", res, exp_r);
                chk("rand_latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
                drop_start();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start_i  input  1  request a divide; held high by EX until ready_o is seen.
REQ-004 SHALL have port: signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have port: annul_i  input  1  pipeline flush; abort the operation in flight.
REQ-006 SHALL have port: dividend_i  input  32  operand rs.
REQ-007 SHALL have port: divisor_i  input  32  operand rt.
REQ-008 SHALL have port: result_o  output  64  {remainder (HI), quotient (LO)}.
REQ-009 SHALL have port: ready_o  output  1  result_o valid.
REQ-010 SHALL have port: stall_o  output  1  EX stall request while a divide is in progress.

Function
REQ-011 SHALL implement states FREE, DIV_BY_ZERO, ON, END.
REQ-012 FREE: start_i=1 and annul_i=0 at an edge SHALL capture operands (absolute values when signed_i=1), record sign flags, clear the 6-bit iteration count, and go to ON; if divisor_i=0, go to DIV_BY_ZERO instead.
REQ-013 ON: each edge SHALL do one restoring shift-subtract step (one quotient bit, MSB first) and increment the count.
REQ-014 ON: after the 32nd step, the edge SHALL apply sign correction and go to END. Quotient is negated when the operand signs differ. Remainder takes the sign of the dividend.
REQ-015 Latency: ready_o SHALL rise exactly 33 cycles after the edge that samples start_i.
REQ-016 DIV_BY_ZERO SHALL go to END on the next edge with quotient=32'hFFFFFFFF and remainder=dividend_i (raw). ready_o therefore rises 2 cycles after start.
REQ-017 END SHALL hold ready_o=1 and a stable result_o. It SHALL return to FREE on the first edge where start_i=0, with ready_o=0 from the next cycle.
REQ-018 stall_o SHALL be 1 in DIV_BY_ZERO and ON. It SHALL also be 1 in FREE while start_i=1 and annul_i=0. It SHALL be 0 in END and otherwise.
REQ-019 annul_i=1 in any state SHALL force the next state to FREE with ready_o=0. No result is produced.
REQ-020 annul_i and start_i both high in FREE SHALL leave the block in FREE.
REQ-021 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0, with no trap.
REQ-022 Operand changes on dividend_i and divisor_i after capture SHALL NOT affect the result.
REQ-023 result_o SHALL be 0 whenever ready_o=0.

Reset
REQ-024 rst_n=0 SHALL immediately force FREE, count 0, all internal registers 0, result_o=0, ready_o=0, stall_o=0.
REQ-025 Reset asserted mid-operation SHALL discard the operation. After release, the block SHALL accept a new start_i on the first clock edge.

Configuration
REQ-026 Macro DIV_ZERO_FLAG_EN defined SHALL add output div_zero_o (1 bit), high together with ready_o only for a divisor of zero, 0 at reset.
REQ-027 Without DIV_ZERO_FLAG_EN, the port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 State encodings, DIV/DIVU alu_op codes and the 64-bit result width SHALL live in the shared defines package.
REQ-029 One combinational sub-module, div_step, SHALL take the 33-bit partial remainder and the divisor and return the next partial remainder and the quotient bit.
REQ-030 The FSM, counter and sign handling SHALL stay in ex_div.

Verification
REQ-031 Unsigned 100/7 -> result_o={32'd2,32'd14}, ready_o exactly 33 cycles after start, stall_o high until then.
REQ-032 Signed -7/2 (32'hFFFFFFF9/2) -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Unsigned 32'hFFFFFFF9/2 -> quotient 32'h7FFFFFFC, remainder 1.
REQ-033 Divisor 0 with dividend 32'h1234 -> after 2 cycles, quotient 32'hFFFFFFFF, remainder 32'h1234, div_zero_o=1 when the macro is defined.
REQ-034 annul_i pulsed at iteration 10 -> FREE next cycle, ready_o stays 0. A new 9/3 then returns {0,3} after 33 cycles.
REQ-035 rst_n low at iteration 20 -> all outputs 0 immediately. start_i held high across release -> a fresh 33-cycle divide.
REQ-036 start_i held high in END for 5 cycles -> result stable and ready_o=1 throughout. Dropping start_i -> ready_o=0 one cycle later.
